// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, MEM-stage redirect flush, memory-wait freeze with watchdog.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  ifid_op,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        exmem_memread,
    input  logic        exmem_memwrite,
    input  logic        mem_ready,
    input  logic        pcsrc,
    input  logic        jump_mem,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        idex_bubble,
    output logic        memwb_bubble,
    output logic        flush,
    output logic        mem_timeout,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] wait_inc;
    logic       timeout_q, timeout_d;
    logic       reads_rt, lu, rd, mb, hold;

    always_comb begin
        reads_rt = (ifid_op == 6'h00) || (ifid_op == 6'h04) || (ifid_op == 6'h2B);
        lu = idex_memread && (idex_rt != 5'd0) &&
             ((idex_rt == ifid_rs) || (reads_rt && (idex_rt == ifid_rt)));
        rd = pcsrc || jump_mem;
        mb = (exmem_memread || exmem_memwrite) && !mem_ready;
        wait_inc = wait_cnt_q + 8'd1;

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        hold       = mb;

        if (state_q == MWAIT) begin
            if (!mb) begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end else if (wait_inc == MAX_WAIT_C) begin
                // Watchdog expiry: let the pipe advance as though the access completed.
                hold       = 1'b0;
                timeout_d  = 1'b1;
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end else begin
                wait_cnt_d = wait_inc;
            end
        end else if (mb) begin
            state_d    = MWAIT;
            wait_cnt_d = 8'd0;
        end

        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        exmem_write  = 1'b1;
        idex_bubble  = 1'b0;
        memwb_bubble = 1'b0;
        flush        = 1'b0;

        if (!rst) begin
            if (hold) begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_write  = 1'b0;
                memwb_bubble = 1'b1;
            end else if (rd) begin
                flush = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush && (flush_cnt_q != 16'hFFFF))     flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = 16'd0;
    assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MAX_WAIT=15).
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ifid_op;
    logic [4:0]  ifid_rs, ifid_rt, idex_rt;
    logic        idex_memread, exmem_memread, exmem_memwrite, mem_ready, pcsrc, jump_mem;
    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        idex_bubble, memwb_bubble, flush, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, memwb_bubble, flush}
    localparam logic [6:0] C_NORM  = 7'b1111_000;
    localparam logic [6:0] C_LU    = 7'b0011_100;
    localparam logic [6:0] C_FLUSH = 7'b1111_001;
    localparam logic [6:0] C_FRZ   = 7'b0000_010;

    hazard_unit #(.MAX_WAIT(15)) dut (
        .clk(clk), .rst(rst),
        .ifid_op(ifid_op), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite),
        .mem_ready(mem_ready), .pcsrc(pcsrc), .jump_mem(jump_mem),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .exmem_write(exmem_write), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
        .flush(flush), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, 16'({pc_write, ifid_write, idex_write, exmem_write,
                      idex_bubble, memwb_bubble, flush}), 16'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ifid_op = 6'h00; ifid_rs = 5'd0; ifid_rt = 5'd0;
        idex_memread = 1'b0; idex_rt = 5'd0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0; mem_ready = 1'b0;
        pcsrc = 1'b0; jump_mem = 1'b0;
    endtask

    task automatic cnt_chk(input string tag, input int s, input int f);
        chk({tag, "_stall"}, stall_cnt, PERF ? 16'(s) : 16'd0);
        chk({tag, "_flush"}, flush_cnt, PERF ? 16'(f) : 16'd0);
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        tick();
        exmem_memread = 1'b1;
        chk_ctl("reset_ctl", C_NORM);
        chk("reset_timeout", 16'(mem_timeout), 16'd0);
        cnt_chk("reset", 0, 0);
        tick();
        clr_in();
        rst = 1'b0;

        chk_ctl("normal", C_NORM);
        tick();

        // lw $2 ; add $3,$2,$4  (rs match)
        idex_memread = 1'b1; idex_rt = 5'd2; ifid_op = 6'h00; ifid_rs = 5'd2; ifid_rt = 5'd4;
        chk_ctl("lu_rs", C_LU);
        tick();
        idex_memread = 1'b0;
        chk_ctl("lu_one_bubble", C_NORM);
        cnt_chk("lu_rs", 1, 0);
        tick();

        // R-type reading rt
        idex_memread = 1'b1; idex_rt = 5'd2; ifid_op = 6'h00; ifid_rs = 5'd5; ifid_rt = 5'd2;
        chk_ctl("lu_rt", C_LU);
        tick();
        cnt_chk("lu_rt", 2, 0);

        // addi with rt equal to load dest: rt is a destination, not a source
        ifid_op = 6'h08; ifid_rs = 5'd0; ifid_rt = 5'd2;
        chk_ctl("addi_no_lu", C_NORM);
        tick();

        // load to $0 never stalls
        idex_rt = 5'd0; ifid_op = 6'h00; ifid_rs = 5'd0; ifid_rt = 5'd0;
        chk_ctl("r0_no_lu", C_NORM);
        tick();

        // taken branch in MEM with a load-use in ID
        idex_rt = 5'd7; ifid_rs = 5'd7; pcsrc = 1'b1;
        chk_ctl("rd_over_lu", C_FLUSH);
        tick();
        clr_in();
        jump_mem = 1'b1;
        chk_ctl("jump_flush", C_FLUSH);
        tick();
        cnt_chk("redirect", 2, 2);
        clr_in();

        // sw with 3 wait cycles
        exmem_memwrite = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_ctl("sw_wait", C_FRZ);
            tick();
        end
        mem_ready = 1'b1;
        chk_ctl("sw_release", C_NORM);
        tick();
        chk("sw_timeout", 16'(mem_timeout), 16'd0);
        cnt_chk("sw", 5, 2);

        // ready on first access cycle
        chk_ctl("sw_fast", C_NORM);
        tick();
        cnt_chk("sw_fast", 5, 2);
        clr_in();

        // watchdog
        exmem_memread = 1'b1;
        for (int i = 0; i < 15; i++) begin
            chk_ctl("wd_frozen", C_FRZ);
            tick();
        end
        chk_ctl("wd_release", C_NORM);
        chk("wd_timeout_pre", 16'(mem_timeout), 16'd0);
        tick();
        clr_in();
        chk("wd_timeout_set", 16'(mem_timeout), 16'd1);
        cnt_chk("wd", 20, 2);
        tick();
        tick();
        chk("wd_timeout_sticky", 16'(mem_timeout), 16'd1);

        // mb beats rd; rd acts on release
        exmem_memread = 1'b1; pcsrc = 1'b1;
        chk_ctl("mb_over_rd", C_FRZ);
        tick();
        mem_ready = 1'b1;
        chk_ctl("rd_after_release", C_FLUSH);
        tick();
        clr_in();
        cnt_chk("mb_rd", 21, 3);

        // reset during 2nd wait cycle
        exmem_memread = 1'b1;
        chk_ctl("rst_mw_c1", C_FRZ);
        tick();
        rst = 1'b1;
        chk_ctl("rst_mw_c2", C_NORM);
        tick();
        rst = 1'b0;
        exmem_memread = 1'b0;
        chk_ctl("post_rst", C_NORM);
        chk("post_rst_timeout", 16'(mem_timeout), 16'd0);
        cnt_chk("post_rst", 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
